// File: rtl/interconnect_two_data_to_sfft.sv
// Merges the even (chet) and odd (Nchet) half-blocks into one NFFT-sample burst for the FFT.
// Each side is buffered to NFFT/2 samples; once both are full and the FFT waits, the block plays out NFFT samples back to back.
module interconnect_two_data_to_sfft #(
  parameter int SIZE_BUFFER   = 3,
  parameter int DATA_FFT_SIZE = 16,
  parameter int INTERLEAVE    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_chet,
  input  logic [DATA_FFT_SIZE-1:0] data_chet_i,
  input  logic [DATA_FFT_SIZE-1:0] data_chet_q,
  output logic                     flag_ready_recive_chet,
  input  logic                     valid_Nchet,
  input  logic [DATA_FFT_SIZE-1:0] data_Nchet_i,
  input  logic [DATA_FFT_SIZE-1:0] data_Nchet_q,
  output logic                     flag_ready_recive_Nchet,
  input  logic                     fft_wayt_data,
  output logic [DATA_FFT_SIZE-1:0] out_data_i,
  output logic [DATA_FFT_SIZE-1:0] out_data_q,
  output logic                     outvalid,
  output logic [SIZE_BUFFER-1:0]   counter_data,
  output logic                     out_last
);

  localparam int NFFT = 1 << SIZE_BUFFER;
  localparam int HALF = NFFT / 2;
  localparam int AW   = SIZE_BUFFER - 1;
  localparam logic [SIZE_BUFFER-1:0] HALF_C = SIZE_BUFFER'(HALF);
  localparam logic [SIZE_BUFFER-1:0] LAST_C = SIZE_BUFFER'(NFFT - 1);
  localparam logic [SIZE_BUFFER-1:0] ONE_C  = SIZE_BUFFER'(1);

  typedef enum logic [1:0] {FILL, WAIT_FFT, SEND} state_t;

  state_t                   state_q, state_d;
  logic [SIZE_BUFFER-1:0]   cnt_chet_q, cnt_chet_d;
  logic [SIZE_BUFFER-1:0]   cnt_nchet_q, cnt_nchet_d;
  logic [SIZE_BUFFER-1:0]   idx_q, idx_d;
  logic [DATA_FFT_SIZE-1:0] dat_i_q, dat_i_d;
  logic [DATA_FFT_SIZE-1:0] dat_q_q, dat_q_d;
  logic                     vld_q, vld_d;
  logic                     last_q, last_d;

  logic [DATA_FFT_SIZE-1:0] chet_i_mem  [HALF];
  logic [DATA_FFT_SIZE-1:0] chet_q_mem  [HALF];
  logic [DATA_FFT_SIZE-1:0] nchet_i_mem [HALF];
  logic [DATA_FFT_SIZE-1:0] nchet_q_mem [HALF];

  logic                     acc_chet, acc_nchet;
  logic [SIZE_BUFFER-1:0]   sel_idx;
  logic                     rd_nchet;
  logic [AW-1:0]            rd_addr;
  logic [DATA_FFT_SIZE-1:0] rd_i, rd_q;

  assign flag_ready_recive_chet  = !reset && (state_q == FILL) && (cnt_chet_q  < HALF_C);
  assign flag_ready_recive_Nchet = !reset && (state_q == FILL) && (cnt_nchet_q < HALF_C);
  assign acc_chet  = valid_chet  && flag_ready_recive_chet;
  assign acc_nchet = valid_Nchet && flag_ready_recive_Nchet;

  always_ff @(posedge clk) begin
    if (acc_chet) begin
      chet_i_mem[cnt_chet_q[AW-1:0]] <= data_chet_i;
      chet_q_mem[cnt_chet_q[AW-1:0]] <= data_chet_q;
    end
    if (acc_nchet) begin
      nchet_i_mem[cnt_nchet_q[AW-1:0]] <= data_Nchet_i;
      nchet_q_mem[cnt_nchet_q[AW-1:0]] <= data_Nchet_q;
    end
  end

  // Index of the sample loaded on the coming edge: 0 when leaving WAIT_FFT, else one past the current one.
  assign sel_idx = (state_q == SEND) ? (idx_q + ONE_C) : '0;

  always_comb begin
    rd_nchet = 1'b0;
    rd_addr  = '0;
    if (INTERLEAVE != 0) begin
      rd_nchet = sel_idx[0];
      rd_addr  = sel_idx[SIZE_BUFFER-1:1];
    end else begin
      rd_nchet = sel_idx[SIZE_BUFFER-1];
      rd_addr  = sel_idx[AW-1:0];
    end
    rd_i = rd_nchet ? nchet_i_mem[rd_addr] : chet_i_mem[rd_addr];
    rd_q = rd_nchet ? nchet_q_mem[rd_addr] : chet_q_mem[rd_addr];
  end

  always_comb begin
    state_d     = state_q;
    cnt_chet_d  = cnt_chet_q;
    cnt_nchet_d = cnt_nchet_q;
    idx_d       = idx_q;
    dat_i_d     = dat_i_q;
    dat_q_d     = dat_q_q;
    vld_d       = vld_q;
    last_d      = last_q;
    if (acc_chet)  cnt_chet_d  = cnt_chet_q + ONE_C;
    if (acc_nchet) cnt_nchet_d = cnt_nchet_q + ONE_C;
    case (state_q)
      FILL: begin
        vld_d  = 1'b0;
        last_d = 1'b0;
        if ((cnt_chet_q == HALF_C) && (cnt_nchet_q == HALF_C)) state_d = WAIT_FFT;
      end
      WAIT_FFT: begin
        if (fft_wayt_data) begin
          state_d = SEND;
          vld_d   = 1'b1;
          idx_d   = '0;
          dat_i_d = rd_i;
          dat_q_d = rd_q;
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (idx_q == LAST_C) begin
          // Block done: data output keeps its last value, both sides reopen.
          state_d     = FILL;
          vld_d       = 1'b0;
          last_d      = 1'b0;
          idx_d       = '0;
          cnt_chet_d  = '0;
          cnt_nchet_d = '0;
        end else begin
          vld_d   = 1'b1;
          idx_d   = sel_idx;
          dat_i_d = rd_i;
          dat_q_d = rd_q;
          last_d  = (sel_idx == LAST_C);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_chet_q  <= '0;
      cnt_nchet_q <= '0;
      idx_q       <= '0;
      dat_i_q     <= '0;
      dat_q_q     <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_chet_q  <= cnt_chet_d;
      cnt_nchet_q <= cnt_nchet_d;
      idx_q       <= idx_d;
      dat_i_q     <= dat_i_d;
      dat_q_q     <= dat_q_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
    end
  end

  assign out_data_i   = dat_i_q;
  assign out_data_q   = dat_q_q;
  assign outvalid     = vld_q;
  assign counter_data = idx_q;
  assign out_last     = last_q;

endmodule
